// File: rtl/light_hash_ctrl_pkg.sv
// rtl/light_hash_ctrl_pkg.sv - shared types, constants and S-box for the light-hash controller
// Package lh_pkg: character bounds, default IV/round count, state enum,
// aes128_sbox() lookup and the alphanumeric character filter.
package lh_pkg;

    localparam logic [7:0] LH_DIGIT_LO = 8'h30;
    localparam logic [7:0] LH_DIGIT_HI = 8'h39;
    localparam logic [7:0] LH_UPPER_LO = 8'h41;
    localparam logic [7:0] LH_UPPER_HI = 8'h5A;
    localparam logic [7:0] LH_LOWER_LO = 8'h61;
    localparam logic [7:0] LH_LOWER_HI = 8'h7A;

    localparam logic [63:0] LH_DEFAULT_IV     = 64'h0123_4567_89AB_CDEF;
    localparam int          LH_DEFAULT_ROUNDS = 32;

    typedef enum logic [1:0] {IDLE, ABSORB, LENGTH, DONE} lh_state_t;

    // Byte 0x00 sits in the most significant byte, so entry x is at bit {~x,3'b111}.
    localparam logic [2047:0] LH_SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes128_sbox(input logic [7:0] x);
        return LH_SBOX_TABLE[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic lh_is_alnum(input logic [7:0] ch);
        return ((ch >= LH_DIGIT_LO) && (ch <= LH_DIGIT_HI)) ||
               ((ch >= LH_UPPER_LO) && (ch <= LH_UPPER_HI)) ||
               ((ch >= LH_LOWER_LO) && (ch <= LH_LOWER_HI));
    endfunction

endpackage

// File: rtl/light_hash_ctrl_if.sv
// rtl/light_hash_ctrl_if.sv - plaintext/digest handshake bundle for the light-hash controller
// Signals: ptxt_char[7:0], ptxt_valid, ptxt_last, ptxt_ready (plaintext stream),
// digest_char[63:0], digest_valid, digest_ready (digest handshake),
// err_invalid_ptxt_char, busy (status).
// Modport slave is the controller side, master is the producer/consumer side.
interface light_hash_ctrl_if;
    logic [7:0]  ptxt_char;
    logic        ptxt_valid;
    logic        ptxt_last;
    logic        ptxt_ready;
    logic [63:0] digest_char;
    logic        digest_valid;
    logic        digest_ready;
    logic        err_invalid_ptxt_char;
    logic        busy;

    modport slave (
        input  ptxt_char, ptxt_valid, ptxt_last, digest_ready,
        output ptxt_ready, digest_char, digest_valid, err_invalid_ptxt_char, busy
    );

    modport master (
        output ptxt_char, ptxt_valid, ptxt_last, digest_ready,
        input  ptxt_ready, digest_char, digest_valid, err_invalid_ptxt_char, busy
    );
endinterface

// File: rtl/light_hash_ctrl_sbox_step.sv
// rtl/light_hash_ctrl_sbox_step.sv - one byte-update step of the light-hash schedule
// Module lh_sbox_step (combinational)
//   h[7:0][7:0] : current chaining bytes, h[i] = H[i]
//   idx[2:0]    : byte being updated
//   c[7:0]      : character being absorbed
//   new_byte    : sbox(((H[(idx+2)%8] ^ c) << idx) truncated to 8 bits)
module lh_sbox_step
    import lh_pkg::*;
(
    input  logic [7:0][7:0] h,
    input  logic [2:0]      idx,
    input  logic [7:0]      c,
    output logic [7:0]      new_byte
);
    logic [2:0] src_idx;
    logic [7:0] mixed;
    logic [7:0] shifted;

    // 3-bit add wraps naturally, giving (idx+2) mod 8.
    assign src_idx  = idx + 3'd2;
    assign mixed    = h[src_idx] ^ c;
    assign shifted  = mixed << idx;
    assign new_byte = aes128_sbox(shifted);
endmodule

// File: rtl/light_hash_ctrl.sv
// rtl/light_hash_ctrl.sv - iterative light-hash sequencing controller
// Ports: clk, rst_n (async active-low), bus (light_hash_ctrl_if.slave).
// Parameters: NUM_ROUNDS (rounds per absorbed character, >=1), IV (initial chaining value).
// Optional macro LH_LEN_FINAL_EN: absorb the valid-character count as a final character.
module light_hash_ctrl
    import lh_pkg::*;
#(
    parameter int          NUM_ROUNDS = LH_DEFAULT_ROUNDS,
    parameter logic [63:0] IV         = LH_DEFAULT_IV
)
(
    input  logic              clk,
    input  logic              rst_n,
    light_hash_ctrl_if.slave  bus
);
    localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
    localparam logic [RW-1:0] ROUND_LAST = RW'(NUM_ROUNDS - 1);

    lh_state_t       state;
    logic [7:0][7:0] h;
    logic [7:0]      c;
    logic            last;
    logic [RW-1:0]   round;
    logic [2:0]      idx;
    logic            err;
    logic [7:0]      step_byte;
`ifdef LH_LEN_FINAL_EN
    logic [7:0]      len;
`endif

    // The single shared S-box: every step of every round goes through here.
    lh_sbox_step u_step (
        .h        (h),
        .idx      (idx),
        .c        (c),
        .new_byte (step_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            h     <= IV;
            c     <= '0;
            last  <= 1'b0;
            round <= '0;
            idx   <= '0;
            err   <= 1'b0;
`ifdef LH_LEN_FINAL_EN
            len   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ptxt_valid) begin
                        last  <= bus.ptxt_last;
                        round <= '0;
                        idx   <= '0;
                        if (lh_is_alnum(bus.ptxt_char)) begin
                            c     <= bus.ptxt_char;
                            state <= ABSORB;
`ifdef LH_LEN_FINAL_EN
                            len   <= len + 8'd1;
`endif
                        end else begin
                            // Invalid characters are dropped; only the flag remembers them.
                            err <= 1'b1;
                            c   <= bus.ptxt_char;
                            if (bus.ptxt_last) begin
`ifdef LH_LEN_FINAL_EN
                                c     <= len;
                                state <= LENGTH;
`else
                                state <= DONE;
`endif
                            end
                        end
                    end
                end
                ABSORB: begin
                    h[idx] <= step_byte;
                    idx    <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        round <= round + RW'(1);
                        if (round == ROUND_LAST) begin
                            round <= '0;
                            if (last) begin
`ifdef LH_LEN_FINAL_EN
                                c     <= len;
                                state <= LENGTH;
`else
                                state <= DONE;
`endif
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
`ifdef LH_LEN_FINAL_EN
                LENGTH: begin
                    h[idx] <= step_byte;
                    idx    <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        round <= round + RW'(1);
                        if (round == ROUND_LAST) begin
                            round <= '0;
                            state <= DONE;
                        end
                    end
                end
`endif
                DONE: begin
                    if (bus.digest_ready) begin
                        state <= IDLE;
                        h     <= IV;
                        err   <= 1'b0;
`ifdef LH_LEN_FINAL_EN
                        len   <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ptxt_ready            = (state == IDLE);
    assign bus.busy                  = (state != IDLE);
    assign bus.digest_valid          = (state == DONE);
    assign bus.digest_char           = (state == DONE) ? h : 64'h0;
    assign bus.err_invalid_ptxt_char = err;
endmodule

// File: tb/tb_light_hash_ctrl.sv
// tb/tb_light_hash_ctrl.sv - directed self-checking bench for light_hash_ctrl
module tb_light_hash_ctrl;
    typedef logic [7:0] bytes_t[$];

    localparam logic [63:0] TB_IV  = 64'h0123_4567_89AB_CDEF;
    localparam int          ROUNDS = 32;
    localparam int          STEPS  = 8 * ROUNDS;
`ifdef LH_LEN_FINAL_EN
    localparam int          LAST_LAT = 2 * STEPS;
`else
    localparam int          LAST_LAT = STEPS;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] sbox_ref [256];

    light_hash_ctrl_if bus ();

    light_hash_ctrl #(.NUM_ROUNDS(ROUNDS), .IV(TB_IV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference S-box built from the GF(2^8) inverse and the AES affine map.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] w = {v, v} << n;
        return w[15:8];
    endfunction

    function automatic logic [7:0] sbox_alg(input logic [7:0] a);
        logic [7:0] inv = 8'h0;
        if (a != 8'h0) begin
            inv = 8'h1;
            for (int k = 0; k < 254; k++) inv = gf_mul(inv, a);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic is_alnum_ref(input logic [7:0] ch);
        return (ch >= "0" && ch <= "9") || (ch >= "A" && ch <= "Z") || (ch >= "a" && ch <= "z");
    endfunction

    function automatic logic [63:0] absorb_ref(input logic [63:0] hv, input logic [7:0] ch);
        logic [15:0] w;
        for (int r = 0; r < ROUNDS; r++) begin
            for (int i = 0; i < 8; i++) begin
                w = {8'h0, hv[((i + 2) % 8) * 8 +: 8] ^ ch} << i;
                hv[i * 8 +: 8] = sbox_ref[w[7:0]];
            end
        end
        return hv;
    endfunction

    function automatic logic [63:0] model_digest(input bytes_t msg);
        logic [63:0] hv = TB_IV;
        logic [7:0]  n = 8'h0;
        foreach (msg[k]) begin
            if (is_alnum_ref(msg[k])) begin
                n  = n + 8'd1;
                hv = absorb_ref(hv, msg[k]);
            end
        end
`ifdef LH_LEN_FINAL_EN
        hv = absorb_ref(hv, n);
`endif
        return hv;
    endfunction

    task automatic send_char(input logic [7:0] ch, input logic lst, output int t);
        int n = 0;
        @(negedge clk);
        bus.ptxt_char  = ch;
        bus.ptxt_valid = 1'b1;
        bus.ptxt_last  = lst;
        while (!bus.ptxt_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.ptxt_ready) begin
            errors++;
            $display("FAIL send_timeout: ptxt_ready=%b required 1", bus.ptxt_ready);
        end
        @(negedge clk);
        bus.ptxt_valid = 1'b0;
        bus.ptxt_last  = 1'b0;
        t = cyc;
    endtask

    // Waits for digest_valid (want_digest) or ptxt_ready; counts cycles where busy was low.
    task automatic wait_done(input int t, input logic want_digest, output int lat, output int viol);
        int n = 0;
        viol = 0;
        while (!(want_digest ? bus.digest_valid : bus.ptxt_ready) && n < 3000) begin
            if (!bus.busy || bus.ptxt_ready) viol++;
            @(negedge clk);
            n++;
        end
        lat = cyc - t;
    endtask

    task automatic take_digest();
        @(negedge clk);
        bus.digest_ready = 1'b1;
        @(negedge clk);
        bus.digest_ready = 1'b0;
        checks++;
        if (bus.digest_valid !== 1'b0 || bus.ptxt_ready !== 1'b1 || bus.digest_char !== 64'h0) begin
            errors++;
            $display("FAIL digest_handshake: valid=%b ready=%b digest=%h required 0 1 0",
                     bus.digest_valid, bus.ptxt_ready, bus.digest_char);
        end
    endtask

    task automatic run_message(input string name, input bytes_t msg, input logic exp_err);
        int t, lat, viol;
        logic [63:0] exp_d;
        exp_d = model_digest(msg);
        foreach (msg[k]) begin
            send_char(msg[k], k == msg.size() - 1, t);
            if (k != msg.size() - 1) begin
                wait_done(t, 1'b0, lat, viol);
                checks++;
                if (is_alnum_ref(msg[k]) ? (lat !== STEPS || viol !== 0) : (lat > 1)) begin
                    errors++;
                    $display("FAIL %s_char%0d_latency: lat=%0d viol=%0d", name, k, lat, viol);
                end
            end else begin
                wait_done(t, 1'b1, lat, viol);
                checks++;
                if (is_alnum_ref(msg[k]) && (lat !== LAST_LAT || viol !== 0)) begin
                    errors++;
                    $display("FAIL %s_digest_latency: lat=%0d required %0d viol=%0d",
                             name, lat, LAST_LAT, viol);
                end
            end
        end
        checks++;
        if (bus.digest_char !== exp_d) begin
            errors++;
            $display("FAIL %s_digest: got %h required %h", name, bus.digest_char, exp_d);
        end
        checks++;
        if (bus.err_invalid_ptxt_char !== exp_err) begin
            errors++;
            $display("FAIL %s_err: got %b required %b", name, bus.err_invalid_ptxt_char, exp_err);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.ptxt_ready !== 1'b1 || bus.busy !== 1'b0 || bus.digest_valid !== 1'b0 ||
            bus.digest_char !== 64'h0 || bus.err_invalid_ptxt_char !== 1'b0) begin
            errors++;
            $display("FAIL %s: ready=%b busy=%b valid=%b digest=%h err=%b required 1 0 0 0 0",
                     name, bus.ptxt_ready, bus.busy, bus.digest_valid, bus.digest_char,
                     bus.err_invalid_ptxt_char);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset_state");
    endtask

    task automatic test_single_a();
        bytes_t q;
        q = {8'h41};
        run_message("single_A", q, 1'b0);
        take_digest();
    endtask

    task automatic test_msg_a1z();
        bytes_t q;
        q = {8'h61, 8'h31, 8'h5A};
        run_message("msg_a1Z", q, 1'b0);
        take_digest();
    endtask

    task automatic test_invalid_then_b();
        int t;
        bytes_t q;
        send_char(8'h20, 1'b0, t);
        checks++;
        if (bus.err_invalid_ptxt_char !== 1'b1) begin
            errors++;
            $display("FAIL invalid_err_sticky: got %b required 1", bus.err_invalid_ptxt_char);
        end
        q = {8'h62};
        run_message("invalid_then_b", q, 1'b1);
        take_digest();
        checks++;
        if (bus.err_invalid_ptxt_char !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b required 0", bus.err_invalid_ptxt_char);
        end
    endtask

    task automatic test_all_invalid();
        bytes_t q;
        logic [63:0] exp_d;
        q = {8'h21, 8'h7E};
        exp_d = model_digest(q);
`ifndef LH_LEN_FINAL_EN
        checks++;
        if (exp_d !== TB_IV) begin
            errors++;
            $display("FAIL all_invalid_model: got %h required %h", exp_d, TB_IV);
        end
`endif
        run_message("all_invalid", q, 1'b1);
        take_digest();
    endtask

    task automatic test_hold_done();
        bytes_t q;
        logic [63:0] held;
        int bad = 0;
        q = {8'h51};
        run_message("hold_Q", q, 1'b0);
        held = bus.digest_char;
        repeat (20) begin
            @(negedge clk);
            if (bus.digest_char !== held || bus.ptxt_ready !== 1'b0 || bus.digest_valid !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_done_stable: %0d unstable cycles required 0", bad);
        end
        take_digest();
        q = {8'h41};
        run_message("after_hold_A", q, 1'b0);
        take_digest();
    endtask

    task automatic test_reset_mid();
        int t;
        bytes_t q;
        send_char(8'h78, 1'b1, t);
        repeat (99) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset_release");
        q = {8'h78};
        run_message("x_after_reset", q, 1'b0);
        take_digest();
    endtask

    initial begin
        bus.ptxt_char    = 8'h0;
        bus.ptxt_valid   = 1'b0;
        bus.ptxt_last    = 1'b0;
        bus.digest_ready = 1'b0;
        for (int i = 0; i < 256; i++) sbox_ref[i] = sbox_alg(8'(i));
        test_reset();
        test_single_a();
        test_msg_a1z();
        test_invalid_then_b();
        test_all_invalid();
        test_hold_done();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
